// File: rtl/pc_fetch_sequencer.sv
// PC owner and IMEM fetch sequencer: BOOT -> REQ -> VALID loop, sticky FAULT on illegal next PC.
// Optional `PCSEQ_FETCH_COUNT_EN adds fetch_count_o (accepted-instruction counter).
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        redir_valid_i,
    input  logic [1:0]  redir_sel_i,
    input  logic [31:0] ext_imm_i,
    input  logic [31:0] rs_val_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
`ifdef PCSEQ_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count_o
`endif
);

    localparam logic [31:0] IMEM_LIMIT = IMEM_BASE + 32'(IMEM_WORDS) * 32'd4;

    typedef enum logic [1:0] {BOOT, REQ, VALID, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        target_ok;
    logic        accept;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = (state_q == VALID) && instr_ready_i;

    always_comb begin
        target = pc_plus4;
        if (redir_valid_i) begin
            case (redir_sel_i)
                2'b00:   target = pc_plus4 + (ext_imm_i << 2);
                2'b01:   target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
                2'b10:   target = rs_val_i;
                default: target = pc_plus4;
            endcase
        end
    end

    // Wrap-around is fine by itself; only alignment and window membership matter.
    assign target_ok = (target[1:0] == 2'b00) && (target >= IMEM_BASE) && (target < IMEM_LIMIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (accept) begin
                    if (target_ok) begin
                        pc_d    = target;
                        state_d = REQ;
                    end else begin
                        fault_d    = 1'b1;
                        fault_pc_d = target;
                        state_d    = FAULT;
                    end
                end
            end
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Decoded straight from state so reset drops the request without waiting for a clock.
    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == VALID);
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;

`ifdef PCSEQ_FETCH_COUNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (accept) cnt_q <= cnt_q + 32'd1;
    end
    assign fetch_count_o = cnt_q;
`endif

endmodule
